// File: rtl/seq_serial_rx.sv
// Serial frame receiver for the start/data/stop sequencer line: recovers the
// LSB-first word, checks the stop bit and offers the word on valid/ready.
module seq_serial_rx #(
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_err
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              good_stop;
  logic              load_word;
  logic              drop_word;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      S_IDLE:  if (!rx) next_state = S_DATA;
      S_DATA: begin
        busy = 1'b1;
        if (bit_cnt == LAST_BIT) next_state = S_STOP;
      end
      S_STOP: begin
        busy       = 1'b1;
        next_state = rx ? S_IDLE : S_BREAK;
      end
      // A line stuck low must see a high sample before a new start is armed
      S_BREAK: if (rx) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // A good frame may replace the held word only if that word leaves this edge
  assign good_stop = (state == S_STOP) && rx;
  assign load_word = good_stop && (!data_valid || data_ready);
  assign drop_word = good_stop && data_valid && !data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= (state == S_STOP) && !rx;

      if (state == S_IDLE) begin
        bit_cnt <= '0;
      end else if (state == S_DATA) begin
        shreg[bit_cnt] <= rx;
        bit_cnt        <= bit_cnt + CW'(1);
      end

      if (load_word) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (drop_word)    overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_serial_rx.sv
// Directed bench for seq_serial_rx: a vector table for the basic flows plus
// hand-written sequences for break, overrun and mid-frame reset.
module tb_seq_serial_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [4:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // exp packs {valid, data[4:0], busy, frame_err, overrun}
  typedef struct {
    string      name;
    logic       rx;
    logic       rdy;
    logic       clr;
    logic       rst;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  seq_serial_rx #(.DATA_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] e(input logic v, input logic [4:0] d,
                                   input logic b, input logic f, input logic o);
    return {v, d, b, f, o};
  endfunction

  task automatic addVec(input string name, input logic r, input logic rdy,
                        input logic clr, input logic rst, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.rx = r; v.rdy = rdy; v.clr = clr; v.rst = rst; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic clr,
                               input logic rst);
    rx = r; data_ready = rdy; clr_err = clr; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {data_valid, data_out, busy, frame_err, overrun};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got v=%0b d=%h b=%0b fe=%0b ov=%0b, want v=%0b d=%h b=%0b fe=%0b ov=%0b",
               name, act[8], act[7:3], act[2], act[1], act[0],
               exp[8], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Start bit plus five data bits, LSB first; the stop edge is driven by the caller
  task automatic frameBody(input logic [4:0] d, input logic rdy);
    applyStimulus(1'b0, rdy, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(d[i], rdy, 1'b0, 1'b0);
  endtask

  initial begin
    // name, rx, rdy, clr, rst, {valid, data, busy, ferr, ovr}
    addVec("reset",        1, 0, 0, 1, e(0, 5'h00, 0, 0, 0));
    addVec("idle",         1, 0, 0, 0, e(0, 5'h00, 0, 0, 0));
    addVec("f16 start",    0, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 b0",       0, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 b1",       1, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 b2",       1, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 b3",       0, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 b4",       1, 0, 0, 0, e(0, 5'h00, 1, 0, 0));
    addVec("f16 stop",     1, 0, 0, 0, e(1, 5'h16, 0, 0, 0));
    addVec("f16 hold",     1, 0, 0, 0, e(1, 5'h16, 0, 0, 0));
    addVec("f16 accept",   1, 1, 0, 0, e(0, 5'h16, 0, 0, 0));
    addVec("f01 start",    0, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 b0",       1, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 b1",       0, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 b2",       0, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 b3",       0, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 b4",       0, 1, 0, 0, e(0, 5'h16, 1, 0, 0));
    addVec("f01 stop",     1, 1, 0, 0, e(1, 5'h01, 0, 0, 0));
    addVec("f1F start",    0, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F b0",       1, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F b1",       1, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F b2",       1, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F b3",       1, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F b4",       1, 1, 0, 0, e(0, 5'h01, 1, 0, 0));
    addVec("f1F stop",     1, 1, 0, 0, e(1, 5'h1F, 0, 0, 0));
    addVec("f1F accept",   1, 1, 0, 0, e(0, 5'h1F, 0, 0, 0));
    addVec("f04 start",    0, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 b0",       0, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 b1",       0, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 b2",       1, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 b3",       0, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 b4",       0, 0, 0, 0, e(0, 5'h1F, 1, 0, 0));
    addVec("f04 stop",     1, 0, 0, 0, e(1, 5'h04, 0, 0, 0));
    addVec("f09 start",    0, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 b0",       1, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 b1",       0, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 b2",       0, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 b3",       1, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 b4",       0, 0, 0, 0, e(1, 5'h04, 1, 0, 0));
    addVec("f09 acc+load", 1, 1, 0, 0, e(1, 5'h09, 0, 0, 0));
    addVec("f09 accept",   1, 1, 0, 0, e(0, 5'h09, 0, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rx, vecs[i].rdy, vecs[i].clr, vecs[i].rst);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    // Framing error followed by a long low line
    frameBody(5'h07, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ferr stop", e(0, 5'h09, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("break hold", e(0, 5'h09, 0, 0, 0));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("break exit", e(0, 5'h09, 0, 0, 0));
    frameBody(5'h03, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("f03 stop", e(1, 5'h03, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("f03 accept", e(0, 5'h03, 0, 0, 0));

    // Overrun, clear, and set-beats-clear on the same edge
    frameBody(5'h0A, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("f0A stop", e(1, 5'h0A, 0, 0, 0));
    frameBody(5'h15, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("f15 overrun", e(1, 5'h0A, 0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr clear", e(1, 5'h0A, 0, 0, 0));
    frameBody(5'h15, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr set wins", e(1, 5'h0A, 0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr clear2", e(1, 5'h0A, 0, 0, 0));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("f0A accept", e(0, 5'h0A, 0, 0, 0));

    // Reset on the third data bit discards the partial frame
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("mid reset", e(0, 5'h00, 0, 0, 0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("post reset idle", e(0, 5'h00, 0, 0, 0));
    frameBody(5'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("f11 stop", e(1, 5'h11, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
